// File: rtl/code_memory_loader.sv
// Writable 16x17 instruction store for the i281 core: reloads from the static
// image on reset or load_img, and can be reprogrammed from a 3-byte-per-word stream.
module code_memory_loader #(
  parameter int WORD_W = 17,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [WORD_W-1:0] b0I,
  input  logic [WORD_W-1:0] b1I,
  input  logic [WORD_W-1:0] b2I,
  input  logic [WORD_W-1:0] b3I,
  input  logic [WORD_W-1:0] b4I,
  input  logic [WORD_W-1:0] b5I,
  input  logic [WORD_W-1:0] b6I,
  input  logic [WORD_W-1:0] b7I,
  input  logic [WORD_W-1:0] b8I,
  input  logic [WORD_W-1:0] b9I,
  input  logic [WORD_W-1:0] b10I,
  input  logic [WORD_W-1:0] b11I,
  input  logic [WORD_W-1:0] b12I,
  input  logic [WORD_W-1:0] b13I,
  input  logic [WORD_W-1:0] b14I,
  input  logic [WORD_W-1:0] b15I,
  input  logic              load_img,
  input  logic              prog_en,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic [ADDR_W-1:0] read_addr,
  output logic [WORD_W-1:0] instr_out,
  output logic              cpu_hold,
  output logic              prog_done,
  output logic              prog_err,
  output logic [ADDR_W-1:0] wr_ptr
);

  typedef enum logic [2:0] {IDLE, B0, B1, B2, WRITE} state_t;

  state_t              state_q, state_d;
  logic [WORD_W-1:0]   mem_q [DEPTH];
  logic [WORD_W-1:0]   mem_d [DEPTH];
  logic [WORD_W-1:0]   img   [DEPTH];
  logic [WORD_W-1:0]   word_q, word_d;
  logic [WORD_W-1:0]   instr_q, instr_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                block_q, block_d;
  logic                xfer;

  assign img[0]  = b0I;   assign img[1]  = b1I;   assign img[2]  = b2I;   assign img[3]  = b3I;
  assign img[4]  = b4I;   assign img[5]  = b5I;   assign img[6]  = b6I;   assign img[7]  = b7I;
  assign img[8]  = b8I;   assign img[9]  = b9I;   assign img[10] = b10I;  assign img[11] = b11I;
  assign img[12] = b12I;  assign img[13] = b13I;  assign img[14] = b14I;  assign img[15] = b15I;

  // Gating with prog_en keeps a byte from being consumed on the abort cycle.
  assign rx_ready  = (state_q inside {B0, B1, B2}) && prog_en;
  assign xfer      = rx_valid && rx_ready;
  assign cpu_hold  = (state_q != IDLE);
  assign instr_out = instr_q;
  assign prog_done = done_q;
  assign prog_err  = err_q;
  assign wr_ptr    = wr_ptr_q;

  always_comb begin
    state_d  = state_q;
    mem_d    = mem_q;
    word_d   = word_q;
    wr_ptr_d = wr_ptr_q;
    done_d   = done_q;
    err_d    = err_q;
    block_d  = block_q;
    instr_d  = mem_q[read_addr];
    case (state_q)
      IDLE: begin
        if (load_img) begin
          mem_d = img;
        end else if (prog_en && !block_q) begin
          state_d  = B0;
          wr_ptr_d = '0;
          done_d   = 1'b0;
          err_d    = 1'b0;
        end
      end
      B0: if (xfer) begin
        word_d[WORD_W-1] = rx_data[0];
        if (|rx_data[7:1]) err_d = 1'b1;
        state_d = B1;
      end
      B1: if (xfer) begin
        word_d[15:8] = rx_data;
        state_d      = B2;
      end
      B2: if (xfer) begin
        word_d[7:0] = rx_data;
        state_d     = WRITE;
      end
      WRITE: begin
        mem_d[wr_ptr_q] = word_q;
        if (wr_ptr_q == ADDR_W'(DEPTH-1)) begin
          wr_ptr_d = '0;
          done_d   = 1'b1;
          block_d  = 1'b1;
          state_d  = IDLE;
        end else begin
          wr_ptr_d = wr_ptr_q + ADDR_W'(1);
          state_d  = B0;
        end
      end
      default: state_d = IDLE;
    endcase
    // A completed program must see prog_en low before it can be restarted.
    if (!prog_en) begin
      block_d = 1'b0;
      if (state_q != IDLE) state_d = IDLE;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q  <= IDLE;
      mem_q    <= img;
      word_q   <= '0;
      instr_q  <= '0;
      wr_ptr_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      block_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      mem_q    <= mem_d;
      word_q   <= word_d;
      instr_q  <= instr_d;
      wr_ptr_q <= wr_ptr_d;
      done_q   <= done_d;
      err_q    <= err_d;
      block_q  <= block_d;
    end
  end

endmodule

// File: tb/tb_code_memory_loader.sv
// Randomized scoreboard bench for code_memory_loader: a transaction-level memory
// model predicts every registered read; a monitor pops and compares each cycle.
module tb_code_memory_loader;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [16:0] img [16];
  logic        load_img, prog_en, rx_valid, rx_ready;
  logic [7:0]  rx_data;
  logic [3:0]  read_addr, wr_ptr;
  logic [16:0] instr_out;
  logic        cpu_hold, prog_done, prog_err;

  int n_vec = 0;
  int n_bad = 0;

  // reference model state
  logic [16:0] mdl_mem [16];
  logic [16:0] exp_q [$];
  logic [16:0] asm_w, pend_w;
  int          bpos, wcnt, pend_a, hs_cnt, wr_viol;
  bit          pend, exp_done, exp_err, pen_prev;
  logic [7:0]  stream [48];

  code_memory_loader dut (
    .Clock(Clock), .Reset(Reset),
    .b0I(img[0]), .b1I(img[1]), .b2I(img[2]), .b3I(img[3]),
    .b4I(img[4]), .b5I(img[5]), .b6I(img[6]), .b7I(img[7]),
    .b8I(img[8]), .b9I(img[9]), .b10I(img[10]), .b11I(img[11]),
    .b12I(img[12]), .b13I(img[13]), .b14I(img[14]), .b15I(img[15]),
    .load_img(load_img), .prog_en(prog_en), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .read_addr(read_addr),
    .instr_out(instr_out), .cpu_hold(cpu_hold), .prog_done(prog_done),
    .prog_err(prog_err), .wr_ptr(wr_ptr)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Model: a stream of bytes, every three form a word that lands in memory
  // one cycle after its last byte; reads see memory as it was before the edge.
  always @(posedge Clock) begin
    if (Reset) begin
      for (int i = 0; i < 16; i++) mdl_mem[i] = img[i];
      exp_q.push_back(17'h0);
      bpos = 0; wcnt = 0; pend = 0; exp_done = 0; exp_err = 0; pen_prev = 0;
    end else begin
      exp_q.push_back(mdl_mem[read_addr]);
      if (pend) begin
        if (rx_ready) wr_viol++;
        mdl_mem[pend_a] = pend_w;
        pend = 0;
        wcnt++;
        if (wcnt == 16) begin wcnt = 0; exp_done = 1; end
      end
      if (load_img) for (int i = 0; i < 16; i++) mdl_mem[i] = img[i];
      if (prog_en && !pen_prev) begin exp_done = 0; exp_err = 0; end
      if (!prog_en) begin
        bpos = 0; wcnt = 0;
      end else if (rx_valid && rx_ready) begin
        hs_cnt++;
        if (bpos == 0) begin
          asm_w[16] = rx_data[0];
          if (rx_data[7:1] != 7'd0) exp_err = 1;
        end else if (bpos == 1) begin
          asm_w[15:8] = rx_data;
        end else begin
          asm_w[7:0] = rx_data;
          pend = 1; pend_a = wcnt; pend_w = asm_w;
        end
        bpos = (bpos + 1) % 3;
      end
      pen_prev = prog_en;
    end
  end

  always @(negedge Clock) begin
    if (exp_q.size() > 0) chk("instr_out", 32'(instr_out), 32'(exp_q.pop_front()));
  end

  task automatic build_stream(input bit rnd);
    for (int k = 0; k < 16; k++) begin
      stream[3*k]   = rnd ? 8'($urandom_range(1)) : 8'h00;
      stream[3*k+1] = rnd ? 8'($urandom) : 8'(k);
      stream[3*k+2] = rnd ? 8'($urandom) : 8'hA5;
    end
  endtask

  task automatic program_img(input int pct, input int limit, output int hold);
    int  base, idx;
    bit  fin;
    base = hs_cnt; hold = 0; fin = 0;
    prog_en = 1'b1;
    for (int c = 0; c < 1000 && !fin; c++) begin
      @(negedge Clock);
      idx = hs_cnt - base;
      if (cpu_hold) hold++;
      if (idx >= limit && (limit < 48 || (!pend && !cpu_hold))) begin
        fin = 1; rx_valid = 1'b0;
        if (limit < 48) prog_en = 1'b0;
      end else begin
        rx_valid  = ($urandom_range(99) < pct);
        rx_data   = (idx < 48) ? stream[idx] : 8'($urandom);
        read_addr = 4'($urandom);
      end
    end
    if (!fin) chk("prog_timeout", 32'd0, 32'd1);
  endtask

  task automatic read_all();
    for (int a = 0; a < 16; a++) begin
      @(negedge Clock);
      read_addr = 4'(a); rx_valid = 1'b0;
    end
    @(negedge Clock);
  endtask

  task automatic check_flags(input string tag, input bit hold, input bit done, input bit err);
    chk({tag, "_cpu_hold"}, 32'(cpu_hold), 32'(hold));
    chk({tag, "_prog_done"}, 32'(prog_done), 32'(done));
    chk({tag, "_prog_err"}, 32'(prog_err), 32'(err));
  endtask

  initial begin
    int hold;
    for (int i = 3; i < 16; i++) img[i] = 17'($urandom);
    img[0] = 17'h1C0F4; img[1] = 17'h0A001; img[2] = 17'h1C0EE;
    hs_cnt = 0; wr_viol = 0;
    Reset = 1'b1; load_img = 1'b0; prog_en = 1'b0; rx_valid = 1'b0;
    rx_data = 8'h00; read_addr = 4'd0;
    repeat (2) @(negedge Clock);
    Reset = 1'b0;
    check_flags("reset", 0, 0, 0);
    chk("reset_rx_ready", 32'(rx_ready), 32'd0);
    chk("reset_wr_ptr", 32'(wr_ptr), 32'd0);
    read_all();

    // full program, rx_valid always high
    build_stream(0);
    program_img(100, 48, hold);
    chk("hold_cycles", 32'(hold), 32'd64);
    check_flags("full", 0, 1, 0);
    chk("full_flag_model", 32'(prog_done), 32'(exp_done));
    chk("full_wr_ptr", 32'(wr_ptr), 32'd0);
    for (int c = 0; c < 4; c++) begin
      @(negedge Clock);
      chk("no_restart", 32'(cpu_hold), 32'd0);
    end
    prog_en = 1'b0;
    read_all();

    // same stream, rx_valid toggling
    program_img(50, 48, hold);
    check_flags("toggle", 0, 1, 0);
    prog_en = 1'b0;
    read_all();

    // random words, bad header on word 5
    build_stream(1);
    stream[15] = 8'h03;
    program_img(70, 48, hold);
    check_flags("hdr_err", 0, 1, 1);
    chk("hdr_err_model", 32'(prog_err), 32'(exp_err));
    prog_en = 1'b0;
    read_all();

    // image reload; read of address 3 in the load cycle sees the old word
    @(negedge Clock);
    load_img = 1'b1; read_addr = 4'd3;
    @(negedge Clock);
    load_img = 1'b0;
    read_all();

    // abort after 7 bytes
    build_stream(1);
    program_img(100, 7, hold);
    @(negedge Clock);
    check_flags("abort", 0, 0, exp_err);
    read_all();

    // reset in the middle of programming
    build_stream(1);
    program_img(100, 10, hold);
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    check_flags("mid_reset", 0, 0, 0);
    read_all();

    // random full program, then reset clears sticky done
    build_stream(1);
    program_img(60, 48, hold);
    check_flags("rand", 0, 1, exp_err);
    read_all();
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0; prog_en = 1'b0;
    check_flags("post_reset", 0, 0, 0);
    read_all();

    chk("rx_ready_in_write", 32'(wr_viol), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/code_memory_loader.md
Name: code_memory_loader

Overview:
- Downstream stage of the user-code image: owns the 16-word x 17-bit instruction memory the multicycle i281 core fetches from.
- On reset, or on request, copies the static image words b0I..b15I into writable storage.
- Supports in-system reprogramming from a byte stream with a valid/ready handshake; serves registered instruction reads to the fetch stage.
- Stalls the core while programming.

Parameters:
- WORD_W, 17, instruction word width
- DEPTH, 16, number of instruction words
- ADDR_W, 4, address width (log2 DEPTH)

Ports:
- Clock  input  1  single system clock, all state on rising edge
- Reset  input  1  synchronous, active-high reset
- b0I..b15I  input  17 each  static user-code image words 0..15
- load_img  input  1  one-cycle pulse: recopy image into memory
- prog_en  input  1  level: enable serial programming mode
- rx_data  input  8  programming byte
- rx_valid  input  1  rx_data valid
- rx_ready  output  1  loader accepts byte this cycle
- read_addr  input  4  fetch address (PC)
- instr_out  output  17  registered instruction word
- cpu_hold  output  1  stall request to core control FSM
- prog_done  output  1  sticky: full 16-word program received
- prog_err  output  1  sticky: malformed header byte seen
- wr_ptr  output  4  next word address to be programmed

Behaviour:
- Clock is the only clock. Reset is synchronous, active-high.
- Reset values:
  - mem[i] = b{i}I for all i
  - instr_out = 0
  - rx_ready = 0, cpu_hold = 0, prog_done = 0, prog_err = 0, wr_ptr = 0
  - state = IDLE
- Read path:
  - instr_out <= mem[read_addr] every cycle, including during programming (1-cycle latency).
  - A read of the address being written in the same cycle returns the old data (read-before-write).
- Image load: load_img high in IDLE overwrites all 16 words from b0I..b15I in one cycle. load_img is ignored outside IDLE.
- States: IDLE, B0, B1, B2, WRITE.
  - IDLE -> B0 when prog_en=1. On entry: wr_ptr <= 0, prog_done <= 0, prog_err <= 0.
  - B0/B1/B2: rx_ready = 1. A byte transfers when rx_valid & rx_ready.
  - B0: byte bit0 -> word[16]. Bits 7:1 must be zero; if not, set prog_err and still store bit0. Go to B1.
  - B1: byte -> word[15:8]. Go to B2.
  - B2: byte -> word[7:0]. Go to WRITE.
  - WRITE: rx_ready = 0. mem[wr_ptr] <= assembled word. If wr_ptr == 15: wr_ptr <= 0, prog_done <= 1, go to IDLE. Otherwise wr_ptr++ and go to B0.
  - No transfer -> remain in current state, partial word held.
- cpu_hold = 1 in any state other than IDLE.
- prog_en deasserted in B0..B2 or WRITE:
  - Abort next cycle to IDLE.
  - A WRITE in progress that cycle still commits.
  - Partial word discarded; prog_done stays 0.
  - Memory keeps words already written.
- prog_en held high after prog_done: no restart until prog_en drops and rises again (edge-qualified entry from IDLE).
- load_img and prog_en both high in IDLE: load_img takes priority this cycle; programming entry happens the next cycle.
- Reset mid-programming: memory reloads the image, all flags clear, state = IDLE.

Test Plan:
- Reset with b0I=17'h1C0F4, b1I=17'h0A001, b2I=17'h1C0EE -> after 1 cycle with read_addr=0/1/2, instr_out = 17'h1C0F4/17'h0A001/17'h1C0EE; all flags 0.
- prog_en=1, stream 48 bytes with rx_valid always 1, word k = {1'b0, 8'hk, 8'hA5} -> mem[k] = {1'b0, k, A5}; cpu_hold high for exactly 64 cycles; prog_done=1; wr_ptr=0.
- Same stream with rx_valid toggling 50% -> identical memory contents; rx_ready never high in WRITE; no byte dropped or duplicated.
- Header byte 8'h03 for word 5 -> prog_err=1; mem[5][16]=1; remaining words correct.
- Drop prog_en after 7 bytes -> mem[0], mem[1] updated; mem[2..15] keep image values; cpu_hold=0 next cycle; prog_done=0.
- After programming, pulse load_img -> all 16 words equal b0I..b15I next cycle; read of address 3 during the load cycle returns the pre-load value.
